cache_mem_arbiter: RTL

//  Shares one higher-level memory block port between ICache refills, DCache refills and DCache evictions.

---
 rtl/cache_arb_pkg.sv | 10 +
 rtl/cache_arb_rr2.sv | 9 +
 rtl/cache_mem_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: state/owner types and block-alignment helper shared by the cache memory arbiter
package cache_arb_pkg;
  localparam int DEF_BLOCK_BITS = 512;
  localparam int DEF_ADDR_BITS  = 32;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RD, ARB_RESP} arb_state_t;
  typedef enum logic [1:0] {OWN_IC, OWN_DC, OWN_EVICT} arb_owner_t;
  function automatic logic [63:0] blk_align(input logic [63:0] a, input int ofs);
    return a & ~((64'd1 << ofs) - 64'd1);
  endfunction
endpackage

// File: rtl/cache_arb_rr2.sv
// cache_arb_rr2: two-way round-robin pick; last=1 means requester 1 won the previous tie-break
module cache_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises ICache refills, DCache refills and DCache evictions onto one memory port
// Define CACHE_ARB_PERF_EN to add saturating grant/evict/busy counters.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int BLOCK_BITS = DEF_BLOCK_BITS,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
`ifdef CACHE_ARB_PERF_EN
  ,parameter int CNT_BITS  = 32
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ic_request_i,
  input  logic [ADDR_BITS-1:0]  ic_addr_i,
  output logic [BLOCK_BITS-1:0] ic_data_o,
  output logic [ADDR_BITS-1:0]  ic_addr_o,
  output logic                  ic_valid_o,
  input  logic                  dc_request_i,
  input  logic [ADDR_BITS-1:0]  dc_addr_i,
  output logic [BLOCK_BITS-1:0] dc_data_o,
  output logic [ADDR_BITS-1:0]  dc_addr_o,
  output logic                  dc_valid_o,
  input  logic                  dc_evict_i,
  input  logic [ADDR_BITS-1:0]  dc_evict_addr_i,
  input  logic [BLOCK_BITS-1:0] dc_evict_data_i,
  output logic                  dc_evict_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_BITS-1:0]  mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i
`ifdef CACHE_ARB_PERF_EN
  ,output logic [CNT_BITS-1:0]  perf_ic_grants_o,
  output logic [CNT_BITS-1:0]   perf_dc_grants_o,
  output logic [CNT_BITS-1:0]   perf_evicts_o,
  output logic [CNT_BITS-1:0]   perf_busy_cycles_o
`endif
);
  localparam int OFS = $clog2(BLOCK_BITS / 8);
  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [BLOCK_BITS-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic rr_last_q, rr_last_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic ic_valid_q, ic_valid_d, dc_valid_q, dc_valid_d, ack_q, ack_d;
  logic [1:0] rr_gnt;
  logic idle, take_ev, take_rd;
  cache_arb_rr2 u_rr (.req({dc_request_i, ic_request_i}), .last(rr_last_q), .gnt(rr_gnt));
  assign idle    = state_q == ARB_IDLE;
  assign take_ev = idle & dc_evict_i;
  assign take_rd = idle & ~dc_evict_i & |rr_gnt;
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rr_last_d  = rr_last_q;
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    ic_valid_d = 1'b0;
    dc_valid_d = 1'b0;
    ack_d      = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (take_ev) begin
          state_d   = ARB_ISSUE;
          owner_d   = OWN_EVICT;
          addr_d    = ADDR_BITS'(blk_align(64'(dc_evict_addr_i), OFS));
          wdata_d   = dc_evict_data_i;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
        end else if (take_rd) begin
          state_d   = ARB_ISSUE;
          owner_d   = rr_gnt[0] ? OWN_IC : OWN_DC;
          addr_d    = ADDR_BITS'(blk_align(64'(rr_gnt[0] ? ic_addr_i : dc_addr_i), OFS));
          rr_last_d = rr_gnt[1];
          mem_req_d = 1'b1;
        end
      end
      ARB_ISSUE: begin
        if (mem_gnt_i) begin
          state_d = owner_q == OWN_EVICT ? ARB_RESP : ARB_WAIT_RD;
          ack_d   = owner_q == OWN_EVICT;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end
      end
      ARB_WAIT_RD: begin
        if (mem_rvalid_i) begin
          state_d    = ARB_RESP;
          rdata_d    = mem_rdata_i;
          ic_valid_d = owner_q == OWN_IC;
          dc_valid_d = owner_q == OWN_DC;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_IC;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rr_last_q  <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      ic_valid_q <= 1'b0;
      dc_valid_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rr_last_q  <= rr_last_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      ic_valid_q <= ic_valid_d;
      dc_valid_q <= dc_valid_d;
      ack_q      <= ack_d;
    end
  end
  // buses are gated by their qualifiers so they read 0 whenever nothing is being presented
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_req_q ? addr_q : '0;
  assign mem_wdata_o    = mem_we_q ? wdata_q : '0;
  assign ic_valid_o     = ic_valid_q;
  assign ic_data_o      = ic_valid_q ? rdata_q : '0;
  assign ic_addr_o      = ic_valid_q ? addr_q : '0;
  assign dc_valid_o     = dc_valid_q;
  assign dc_data_o      = dc_valid_q ? rdata_q : '0;
  assign dc_addr_o      = dc_valid_q ? addr_q : '0;
  assign dc_evict_ack_o = ack_q;
`ifdef CACHE_ARB_PERF_EN
  logic [CNT_BITS-1:0] ic_cnt_q, ic_cnt_d, dc_cnt_q, dc_cnt_d, ev_cnt_q, ev_cnt_d, busy_cnt_q, busy_cnt_d;
  always_comb begin
    ic_cnt_d   = ic_cnt_q + CNT_BITS'(take_rd & rr_gnt[0] & ~&ic_cnt_q);
    dc_cnt_d   = dc_cnt_q + CNT_BITS'(take_rd & rr_gnt[1] & ~&dc_cnt_q);
    ev_cnt_d   = ev_cnt_q + CNT_BITS'(take_ev & ~&ev_cnt_q);
    busy_cnt_d = busy_cnt_q + CNT_BITS'(~idle & ~&busy_cnt_q);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ic_cnt_q   <= '0;
      dc_cnt_q   <= '0;
      ev_cnt_q   <= '0;
      busy_cnt_q <= '0;
    end else begin
      ic_cnt_q   <= ic_cnt_d;
      dc_cnt_q   <= dc_cnt_d;
      ev_cnt_q   <= ev_cnt_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end
  assign perf_ic_grants_o   = ic_cnt_q;
  assign perf_dc_grants_o   = dc_cnt_q;
  assign perf_evicts_o      = ev_cnt_q;
  assign perf_busy_cycles_o = busy_cnt_q;
`endif
endmodule
